// File: rtl/tcu_drl_fp32_accum_seq.sv
`default_nettype none
// ============================================================================
// Module      : tcu_drl_fp32_accum_seq (with VX_tcu_drl_fp32add)
// Description : Reduces a packet of N fp32 operands into an fp32 accumulator
//               using one shared combinational adder, one add per cycle.
// Revision    : 1.0 - initial release
// ============================================================================

module VX_tcu_drl_fp32add (
    input  logic        en,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    // Round-to-nearest-even; subnormal inputs read as zero, underflow flushes to zero.
    localparam logic [31:0] C_QNAN = 32'h7FC0_0000;

    logic               w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic               w_swap;
    logic [31:0]        w_big, w_small;
    logic [7:0]         w_diff;
    logic [26:0]        w_mb, w_ms, w_ms_shr, w_lost_mask, w_ms_al;
    logic               w_sticky_al;
    logic [27:0]        w_sum;
    logic [4:0]         w_lz;
    logic [26:0]        w_norm_shl;
    logic [23:0]        w_mant;
    logic               w_guard, w_sticky, w_rnd;
    logic [24:0]        w_mant_rnd;
    logic signed [9:0]  w_exp, w_exp_fin;
    logic [22:0]        w_frac_fin;
    logic [31:0]        w_finite;

    assign w_a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    assign w_b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    assign w_a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    assign w_b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    assign w_a_zero = (a[30:23] == 8'h00);
    assign w_b_zero = (b[30:23] == 8'h00);

    assign w_swap  = b[30:0] > a[30:0];
    assign w_big   = w_swap ? b : a;
    assign w_small = w_swap ? a : b;
    assign w_diff  = w_big[30:23] - w_small[30:23];

    // Three extra LSBs hold guard, round and sticky through alignment.
    assign w_mb        = {1'b1, w_big[22:0], 3'b000};
    assign w_ms        = {1'b1, w_small[22:0], 3'b000};
    assign w_ms_shr    = w_ms >> w_diff;
    assign w_lost_mask = ~({27{1'b1}} << w_diff);
    assign w_sticky_al = |(w_ms & w_lost_mask);
    assign w_ms_al     = {w_ms_shr[26:1], w_ms_shr[0] | w_sticky_al};

    assign w_sum = (w_big[31] ^ w_small[31]) ? ({1'b0, w_mb} - {1'b0, w_ms_al})
                                             : ({1'b0, w_mb} + {1'b0, w_ms_al});

    always_comb begin
        w_lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (w_sum[i]) begin
                w_lz = 5'(26 - i);
            end
        end
    end

    assign w_norm_shl = w_sum[26:0] << w_lz;

    always_comb begin
        w_mant     = 24'd0;
        w_guard    = 1'b0;
        w_sticky   = 1'b0;
        w_exp      = 10'sd0;
        w_exp_fin  = 10'sd0;
        w_frac_fin = 23'd0;
        w_finite   = 32'd0;
        if (w_sum[27]) begin
            w_mant   = w_sum[27:4];
            w_guard  = w_sum[3];
            w_sticky = |w_sum[2:0];
            w_exp    = $signed({2'b00, w_big[30:23]}) + 10'sd1;
        end else begin
            w_mant   = w_norm_shl[26:3];
            w_guard  = w_norm_shl[2];
            w_sticky = |w_norm_shl[1:0];
            w_exp    = $signed({2'b00, w_big[30:23]}) - $signed({5'b00000, w_lz});
        end
        w_rnd      = w_guard & (w_sticky | w_mant[0]);
        w_mant_rnd = {1'b0, w_mant} + {24'd0, w_rnd};
        if (w_mant_rnd[24]) begin
            w_exp_fin  = w_exp + 10'sd1;
            w_frac_fin = w_mant_rnd[23:1];
        end else begin
            w_exp_fin  = w_exp;
            w_frac_fin = w_mant_rnd[22:0];
        end
        if (w_sum == 28'd0) begin
            w_finite = 32'd0;
        end else if (w_exp_fin >= 10'sd255) begin
            w_finite = {w_big[31], 8'hFF, 23'd0};
        end else if (w_exp_fin <= 10'sd0) begin
            w_finite = {w_big[31], 31'd0};
        end else begin
            w_finite = {w_big[31], w_exp_fin[7:0], w_frac_fin};
        end
    end

    always_comb begin
        y = 32'd0;
        if (en) begin
            if (w_a_nan || w_b_nan) begin
                y = C_QNAN;
            end else if (w_a_inf && w_b_inf) begin
                y = (a[31] == b[31]) ? a : C_QNAN;
            end else if (w_a_inf) begin
                y = a;
            end else if (w_b_inf) begin
                y = b;
            end else if (w_a_zero && w_b_zero) begin
                y = {a[31] & b[31], 31'd0};
            end else if (w_a_zero) begin
                y = b;
            end else if (w_b_zero) begin
                y = a;
            end else begin
                y = w_finite;
            end
        end
    end
endmodule

module tcu_drl_fp32_accum_seq #(
    parameter int N    = 4,
    parameter int TAGW = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_c,
    input  logic [N*32-1:0]            in_x,
    input  logic [TAGW-1:0]            in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_sum,
    output logic [TAGW-1:0]            out_tag,
    output logic [$clog2(N+1)-1:0]     out_adds,
    output logic                       busy
);
    localparam int             CNT_W    = $clog2(N + 1);
    localparam int             IDX_W    = $clog2(N);
    localparam logic [N-1:0]   MASK_LSB = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [31:0]        r_x [N];
    logic [31:0]        r_acc;
    logic [TAGW-1:0]    r_tag;
    logic [N-1:0]       r_mask;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_in_ready, r_out_valid, r_busy;

    logic [N-1:0]       w_nz;
    logic [IDX_W-1:0]   w_idx;
    logic               w_last;
    logic               w_add_en;
    logic [31:0]        w_add_y;

    // Both +0 and -0 are skipped, so the sign bit is ignored here.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_nz
            assign w_nz[gi] = |in_x[32*gi +: 31];
        end
    endgenerate

    always_comb begin
        w_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    assign w_last   = ((r_mask & (r_mask - MASK_LSB)) == '0);
    assign w_add_en = (r_state == ST_ACCUM);

    VX_tcu_drl_fp32add u_add (
        .en (w_add_en),
        .a  (r_acc),
        .b  (r_x[w_idx]),
        .y  (w_add_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_acc       <= 32'd0;
            r_tag       <= '0;
            r_mask      <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_x[i] <= 32'd0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < N; i++) begin
                            r_x[i] <= in_x[32*i +: 32];
                        end
                        r_acc      <= in_c;
                        r_tag      <= in_tag;
                        r_mask     <= w_nz;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (w_nz != '0) begin
                            r_state <= ST_ACCUM;
                        end else begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                ST_ACCUM: begin
                    r_acc  <= w_add_y;
                    r_mask <= r_mask & ~(MASK_LSB << w_idx);
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_sum   = r_acc;
    assign out_tag   = r_tag;
    assign out_adds  = r_cnt;
endmodule
`default_nettype wire

// File: tb/tb_tcu_drl_fp32_accum_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_tcu_drl_fp32_accum_seq
// Description : Directed and randomized checks of the sequential fp32 reducer
//               against a real-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tcu_drl_fp32_accum_seq;
    localparam int N    = 4;
    localparam int TAGW = 8;

    typedef logic [31:0] xvec_t [N];

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [31:0]            in_c = 32'd0;
    logic [N*32-1:0]        in_x = '0;
    logic [TAGW-1:0]        in_tag = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [31:0]            out_sum;
    logic [TAGW-1:0]        out_tag;
    logic [$clog2(N+1)-1:0] out_adds;
    logic                   busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int t_acc = 0;
    int t_hs  = 0;

    tcu_drl_fp32_accum_seq #(.N(N), .TAGW(TAGW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_c      (in_c),
        .in_x      (in_x),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_tag   (out_tag),
        .out_adds  (out_adds),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic real to_real(input logic [31:0] f);
        logic [10:0] e11;
        if (f[30:23] == 8'd0) return 0.0;
        e11 = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e11, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] to_fp32(input real r);
        logic [63:0] d;
        logic [24:0] m;
        int          e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        m = {2'b01, d[51:29]};
        if (d[28] && ((|d[27:0]) || m[0])) m = m + 25'd1;
        if (m[24]) begin
            e = e + 1;
            m = m >> 1;
        end
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        if (e <= 0)   return {d[63], 31'd0};
        return {d[63], 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic a_nan, b_nan, a_inf, b_inf;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        if (a_nan || b_nan) return 32'h7FC00000;
        if (a_inf && b_inf) return (a[31] == b[31]) ? a : 32'h7FC00000;
        if (a_inf) return a;
        if (b_inf) return b;
        if (to_real(a) == 0.0 && to_real(b) == 0.0) return {a[31] & b[31], 31'd0};
        return to_fp32(to_real(a) + to_real(b));
    endfunction

    task automatic ref_pkt(input logic [31:0] c, input xvec_t xs,
                           output logic [31:0] sum, output int k);
        sum = c;
        k   = 0;
        for (int i = 0; i < N; i++) begin
            if (xs[i][30:0] != 31'd0) begin
                sum = fp_add(sum, xs[i]);
                k++;
            end
        end
    endtask

    function automatic logic [31:0] rnd_norm();
        logic [31:0] s, e, f;
        s = $urandom_range(0, 1);
        e = $urandom_range(110, 140);
        f = $urandom;
        return {s[0], e[7:0], f[22:0]};
    endfunction

    // ---------------- checking / driving ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic stage(input logic [31:0] c, input xvec_t xs, input logic [TAGW-1:0] tag);
        in_c = c;
        for (int i = 0; i < N; i++) in_x[32*i +: 32] = xs[i];
        in_tag   = tag;
        in_valid = 1'b1;
    endtask

    task automatic send(input logic [31:0] c, input xvec_t xs, input logic [TAGW-1:0] tag);
        int n;
        stage(c, xs, tag);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept", 32'(in_ready), 32'd1);
        t_acc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input logic [31:0] exp_sum, input logic [31:0] mask,
                               input logic [TAGW-1:0] exp_tag, input int k, input int hold);
        while (!out_valid && (cyc - t_acc) < 60) @(negedge clk);
        chk("latency", 32'(cyc - t_acc), 32'(k + 1));
        chk("sum", out_sum & mask, exp_sum & mask);
        chk("tag", 32'(out_tag), 32'(exp_tag));
        chk("adds", 32'(out_adds), 32'(k));
        chk("ready_busy", {30'd0, in_ready, busy}, 32'd1);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            @(negedge clk);
            chk("hold_sum", out_sum & mask, exp_sum & mask);
            chk("hold_ctl", 32'({out_valid, in_ready, out_adds, out_tag}),
                32'({1'b1, 1'b0, 3'(k), exp_tag}));
        end
        out_ready = 1'b1;
        t_hs = cyc;
    endtask

    task automatic after_hs();
        @(negedge clk);
        chk("idle", {29'd0, out_valid, in_ready, busy}, 32'b010);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        xvec_t       xs, xs2;
        logic [31:0] c, c2, e_sum, e_sum2;
        int          k, k2, seen;

        @(negedge clk);
        @(negedge clk);
        chk("rst_ctl", 32'({out_valid, in_ready, busy, out_adds, out_tag}), 32'({3'b010, 3'd0, 8'd0}));
        chk("rst_sum", out_sum, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1 + (1 + 2 + 3) = 7, trailing zero skipped
        xs = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h00000000};
        send(32'h3F800000, xs, 8'hA5);
        wait_result(32'h40E00000, 32'hFFFFFFFF, 8'hA5, 3, 0);
        after_hs();

        // all-zero operands: c passes through untouched
        xs = '{32'h00000000, 32'h80000000, 32'h00000000, 32'h80000000};
        send(32'h40800000, xs, 8'h3C);
        wait_result(32'h40800000, 32'hFFFFFFFF, 8'h3C, 0, 0);
        after_hs();

        // backpressure with a second packet waiting
        xs  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h00000000};
        xs2 = '{32'h3F800000, 32'h00000000, 32'h00000000, 32'h00000000};
        send(32'h3F800000, xs, 8'h5A);
        stage(32'h40000000, xs2, 8'h77);
        wait_result(32'h40E00000, 32'hFFFFFFFF, 8'h5A, 3, 5);
        send(32'h40000000, xs2, 8'h77);
        chk("gap_hold", 32'(t_acc - t_hs), 32'd1);
        wait_result(32'h40400000, 32'hFFFFFFFF, 8'h77, 1, 0);
        after_hs();

        // +inf + -inf -> NaN with quiet fraction
        xs = '{32'hFF800000, 32'h00000000, 32'h00000000, 32'h00000000};
        send(32'h7F800000, xs, 8'h0F);
        wait_result(32'h7FC00000, 32'h7FFFFFFF, 8'h0F, 1, 0);
        after_hs();

        // reset after the second add of a four-add packet
        xs = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        send(32'h3F800000, xs, 8'h99);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_ctl", 32'({out_valid, in_ready, busy, out_adds}), 32'({3'b010, 3'd0}));
        chk("abort_sum", out_sum, 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("abort_no_result", 32'(seen), 32'd0);

        // back-to-back packets with in_valid held high
        for (int i = 0; i < N; i++) begin
            xs[i]  = ($urandom_range(0, 3) == 0) ? 32'h0 : rnd_norm();
            xs2[i] = ($urandom_range(0, 3) == 0) ? 32'h80000000 : rnd_norm();
        end
        c  = rnd_norm();
        c2 = rnd_norm();
        ref_pkt(c, xs, e_sum, k);
        ref_pkt(c2, xs2, e_sum2, k2);
        send(c, xs, 8'h11);
        stage(c2, xs2, 8'h22);
        wait_result(e_sum, 32'hFFFFFFFF, 8'h11, k, 0);
        send(c2, xs2, 8'h22);
        chk("gap_b2b", 32'(t_acc - t_hs), 32'd1);
        wait_result(e_sum2, 32'hFFFFFFFF, 8'h22, k2, 0);
        after_hs();

        // randomized packets
        for (int p = 0; p < 24; p++) begin
            logic [31:0] r;
            for (int i = 0; i < N; i++) begin
                r = $urandom_range(0, 4);
                if (r == 0)      xs[i] = 32'h00000000;
                else if (r == 1) xs[i] = 32'h80000000;
                else             xs[i] = rnd_norm();
            end
            c = rnd_norm();
            ref_pkt(c, xs, e_sum, k);
            send(c, xs, 8'(p + 8'h40));
            wait_result(e_sum, 32'hFFFFFFFF, 8'(p + 8'h40), k, int'($urandom_range(0, 2)));
            after_hs();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
